// File: rtl/snake_body_streamer_pkg.sv
// Shared snake geometry, FSM states and direction encoding.
// The renderer imports the same definitions to decode the body stream.
package snake_body_streamer_pkg;

    localparam int unsigned SNAKE_LENGTH_BIT = 4;
    localparam int unsigned SNAKE_LENGTH_MAX = 16;
    localparam int unsigned GRID_W           = 124;
    localparam int unsigned GRID_H           = 81;
    localparam int unsigned COORD_W          = 7;
    // One extra bit so a completely full body (SNAKE_LENGTH_MAX) is representable.
    localparam int unsigned LEN_W            = SNAKE_LENGTH_BIT + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SHIFT,
        ST_SCAN,
        ST_DEAD
    } snake_state_e;

    typedef enum logic [3:0] {
        DIR_UP    = 4'b1000,
        DIR_DOWN  = 4'b0100,
        DIR_LEFT  = 4'b0010,
        DIR_RIGHT = 4'b0001
    } snake_dir_e;

    function automatic snake_dir_e opposite_dir(snake_dir_e d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    // Highest-priority request wins (up > down > right > left); a reversal is ignored.
    function automatic snake_dir_e next_dir(snake_dir_e cur, logic req_up, logic req_down,
                                            logic req_left, logic req_right);
        snake_dir_e req;
        req = cur;
        if (req_up)         req = DIR_UP;
        else if (req_down)  req = DIR_DOWN;
        else if (req_right) req = DIR_RIGHT;
        else if (req_left)  req = DIR_LEFT;
        return (req == opposite_dir(cur)) ? cur : req;
    endfunction

endpackage

// File: rtl/snake_body_streamer.sv
// Snake position state (head, body shift register, length, direction) with
// move/grow/collision handling and a free-running body-coordinate stream.
module snake_body_streamer
    import snake_body_streamer_pkg::*;
#(
    parameter logic [COORD_W-1:0] START_X     = 7'd62,
    parameter logic [COORD_W-1:0] START_Y     = 7'd40,
    parameter int unsigned        INIT_LENGTH = 3
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        move_tick,
    input  logic                        restart,
    input  logic                        grow,
    input  logic                        up,
    input  logic                        down,
    input  logic                        left,
    input  logic                        right,
    output logic [COORD_W-1:0]          snake_head_x,
    output logic [COORD_W-1:0]          snake_head_y,
    output logic [COORD_W-1:0]          snake_body_x,
    output logic [COORD_W-1:0]          snake_body_y,
    output logic [SNAKE_LENGTH_BIT-1:0] body_count,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic                        dir_up,
    output logic                        dir_down,
    output logic                        dir_left,
    output logic                        dir_right,
    output logic                        busy,
    output logic                        game_over
);

    function automatic logic [COORD_W-1:0] init_x(int unsigned i);
        return (i < INIT_LENGTH) ? START_X - COORD_W'(i + 1) : '1;
    endfunction

    function automatic logic [COORD_W-1:0] init_y(int unsigned i);
        return (i < INIT_LENGTH) ? START_Y : '1;
    endfunction

    snake_state_e                state_q, state_d;
    snake_dir_e                  dir_q, dir_d;
    logic [COORD_W-1:0]          head_x_q, head_x_d, head_y_q, head_y_d;
    logic [COORD_W-1:0]          body_x_q [SNAKE_LENGTH_MAX];
    logic [COORD_W-1:0]          body_x_d [SNAKE_LENGTH_MAX];
    logic [COORD_W-1:0]          body_y_q [SNAKE_LENGTH_MAX];
    logic [COORD_W-1:0]          body_y_d [SNAKE_LENGTH_MAX];
    logic [LEN_W-1:0]            len_q, len_d, scan_idx_q, scan_idx_d;
    logic                        grow_pending_q, grow_pending_d;
    logic                        game_over_q, game_over_d;
    logic                        busy_q, busy_d;
    logic [SNAKE_LENGTH_BIT-1:0] body_count_q, body_count_d;
    logic [COORD_W-1:0]          stream_x_q, stream_x_d, stream_y_q, stream_y_d;
    logic                        wall_hit;

    always_comb begin
        wall_hit = (dir_q == DIR_LEFT  && head_x_q == '0) ||
                   (dir_q == DIR_RIGHT && head_x_q == COORD_W'(GRID_W - 1)) ||
                   (dir_q == DIR_UP    && head_y_q == '0) ||
                   (dir_q == DIR_DOWN  && head_y_q == COORD_W'(GRID_H - 1));
    end

    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        head_x_d       = head_x_q;
        head_y_d       = head_y_q;
        body_x_d       = body_x_q;
        body_y_d       = body_y_q;
        len_d          = len_q;
        scan_idx_d     = scan_idx_q;
        grow_pending_d = grow_pending_q;
        game_over_d    = game_over_q;
        // Stream reads the pre-edge body so each x/y pair comes from one snapshot.
        body_count_d   = body_count_q + 1'b1;
        stream_x_d     = body_x_q[body_count_d];
        stream_y_d     = body_y_q[body_count_d];

        if (restart) begin
            state_d        = ST_RUN;
            dir_d          = DIR_RIGHT;
            head_x_d       = START_X;
            head_y_d       = START_Y;
            len_d          = LEN_W'(INIT_LENGTH);
            scan_idx_d     = '0;
            grow_pending_d = 1'b0;
            game_over_d    = 1'b0;
            body_count_d   = '0;
            stream_x_d     = init_x(0);
            stream_y_d     = init_y(0);
            for (int unsigned i = 0; i < SNAKE_LENGTH_MAX; i++) begin
                body_x_d[i] = init_x(i);
                body_y_d[i] = init_y(i);
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    dir_d = next_dir(dir_q, up, down, left, right);
                    if (grow)      grow_pending_d = 1'b1;
                    if (move_tick) state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (wall_hit) begin
                        game_over_d = 1'b1;
                        state_d     = ST_DEAD;
                    end else begin
                        for (int unsigned i = 1; i < SNAKE_LENGTH_MAX; i++) begin
                            body_x_d[i] = body_x_q[i-1];
                            body_y_d[i] = body_y_q[i-1];
                        end
                        body_x_d[0] = head_x_q;
                        body_y_d[0] = head_y_q;
                        case (dir_q)
                            DIR_UP:   head_y_d = head_y_q - 1'b1;
                            DIR_DOWN: head_y_d = head_y_q + 1'b1;
                            DIR_LEFT: head_x_d = head_x_q - 1'b1;
                            default:  head_x_d = head_x_q + 1'b1;
                        endcase
                        if (grow_pending_q && len_q < LEN_W'(SNAKE_LENGTH_MAX))
                            len_d = len_q + 1'b1;
                        grow_pending_d = grow;
                        scan_idx_d     = '0;
                        state_d        = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (grow) grow_pending_d = 1'b1;
                    // Index len_q is the closing cycle of the scan; no segment is compared there.
                    if (scan_idx_q == len_q) begin
                        state_d = ST_RUN;
                    end else if (head_x_q == body_x_q[scan_idx_q[SNAKE_LENGTH_BIT-1:0]] &&
                                 head_y_q == body_y_q[scan_idx_q[SNAKE_LENGTH_BIT-1:0]]) begin
                        game_over_d = 1'b1;
                        state_d     = ST_DEAD;
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == ST_SHIFT) || (state_d == ST_SCAN);
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            dir_q          <= DIR_RIGHT;
            head_x_q       <= START_X;
            head_y_q       <= START_Y;
            len_q          <= LEN_W'(INIT_LENGTH);
            scan_idx_q     <= '0;
            grow_pending_q <= 1'b0;
            game_over_q    <= 1'b0;
            busy_q         <= 1'b0;
            body_count_q   <= '0;
            stream_x_q     <= init_x(0);
            stream_y_q     <= init_y(0);
            for (int unsigned i = 0; i < SNAKE_LENGTH_MAX; i++) begin
                body_x_q[i] <= init_x(i);
                body_y_q[i] <= init_y(i);
            end
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            head_x_q       <= head_x_d;
            head_y_q       <= head_y_d;
            len_q          <= len_d;
            scan_idx_q     <= scan_idx_d;
            grow_pending_q <= grow_pending_d;
            game_over_q    <= game_over_d;
            busy_q         <= busy_d;
            body_count_q   <= body_count_d;
            stream_x_q     <= stream_x_d;
            stream_y_q     <= stream_y_d;
            body_x_q       <= body_x_d;
            body_y_q       <= body_y_d;
        end
    end

    assign snake_head_x = head_x_q;
    assign snake_head_y = head_y_q;
    assign snake_body_x = stream_x_q;
    assign snake_body_y = stream_y_q;
    assign body_count   = body_count_q;
    // A completely full body wraps to 0 on this narrower port.
    assign snake_length = len_q[SNAKE_LENGTH_BIT-1:0];
    assign dir_up       = (dir_q == DIR_UP);
    assign dir_down     = (dir_q == DIR_DOWN);
    assign dir_left     = (dir_q == DIR_LEFT);
    assign dir_right    = (dir_q == DIR_RIGHT);
    assign busy         = busy_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_snake_body_streamer.sv
// Directed plus randomized bench for snake_body_streamer against a
// queue-free array model of the snake written from the game rules.
module tb_snake_body_streamer;

    logic       clock_25 = 1'b0;
    logic       reset = 1'b0;
    logic       move_tick = 1'b0, restart = 1'b0, grow = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [6:0] snake_head_x, snake_head_y, snake_body_x, snake_body_y;
    logic [3:0] body_count, snake_length;
    logic       dir_up, dir_down, dir_left, dir_right, busy, game_over;

    int checks = 0;
    int failures = 0;

    always #20 clock_25 = ~clock_25;

    snake_body_streamer #(.START_X(7'd62), .START_Y(7'd40), .INIT_LENGTH(3)) dut (
        .clock_25(clock_25), .reset(reset), .move_tick(move_tick), .restart(restart),
        .grow(grow), .up(up), .down(down), .left(left), .right(right),
        .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
        .snake_body_x(snake_body_x), .snake_body_y(snake_body_y),
        .body_count(body_count), .snake_length(snake_length),
        .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
        .busy(busy), .game_over(game_over)
    );

    // Model: direction 0=up 1=down 2=left 3=right, so the reverse is d^1.
    int mx[16], my[16];
    int mhx, mhy, mlen, mdir;
    bit mpend, mdead;

    localparam logic [3:0] R_UP = 4'b1000, R_DOWN = 4'b0100, R_LEFT = 4'b0010, R_RIGHT = 4'b0001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        mhx = 62; mhy = 40; mlen = 3; mdir = 3; mpend = 0; mdead = 0;
        for (int i = 0; i < 16; i++) begin
            mx[i] = (i < 3) ? 61 - i : 127;
            my[i] = (i < 3) ? 40 : 127;
        end
    endtask

    function automatic int pick_dir(int cur, logic [3:0] req);
        int want = -1;
        if (req[3])      want = 0;
        else if (req[2]) want = 1;
        else if (req[0]) want = 3;
        else if (req[1]) want = 2;
        return (want >= 0 && want != (cur ^ 1)) ? want : cur;
    endfunction

    // Advances the model one block; returns the expected number of busy cycles.
    task automatic model_move(output int exp_busy);
        int nx = mhx, ny = mhy;
        bit hit = 0;
        case (mdir)
            0: ny--;
            1: ny++;
            2: nx--;
            default: nx++;
        endcase
        if (nx < 0 || nx >= 124 || ny < 0 || ny >= 81) begin
            mdead = 1; exp_busy = 1;
        end else begin
            for (int i = 15; i >= 1; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
            mx[0] = mhx; my[0] = mhy; mhx = nx; mhy = ny;
            if (mpend && mlen < 16) mlen++;
            mpend = 0;
            exp_busy = mlen + 2;
            for (int i = 0; i < mlen; i++)
                if (!hit && mx[i] == mhx && my[i] == mhy) begin
                    hit = 1; mdead = 1; exp_busy = i + 2;
                end
        end
    endtask

    task automatic check_state();
        logic [3:0] exp_dir;
        exp_dir = 4'b1000 >> mdir;
        chk("head_x", snake_head_x, mhx);
        chk("head_y", snake_head_y, mhy);
        chk("length", snake_length, mlen % 16);
        chk("dir", {dir_up, dir_down, dir_left, dir_right}, exp_dir);
        chk("game_over", game_over, mdead);
        chk("busy_idle", busy, 0);
    endtask

    // Walks one full stream period and compares each triple with the model body.
    task automatic check_stream();
        int k;
        k = body_count;
        chk("stream_pair", {snake_body_x, snake_body_y}, {mx[k][6:0], my[k][6:0]});
        for (int j = 0; j < 15; j++) begin
            @(negedge clock_25);
            k = (k + 1) % 16;
            chk("body_count_step", body_count, k);
            chk("stream_pair", {snake_body_x, snake_body_y}, {mx[k][6:0], my[k][6:0]});
        end
    endtask

    task automatic do_move(input logic [3:0] req, input bit extra_tick);
        int eb, n;
        {up, down, left, right} = req;
        move_tick = 1'b1;
        if (!mdead) mdir = pick_dir(mdir, req);
        @(negedge clock_25);
        {up, down, left, right} = 4'b0000;
        move_tick = 1'b0;
        if (!mdead) model_move(eb); else eb = 0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            move_tick = (extra_tick && n == 2);
            @(negedge clock_25);
        end
        move_tick = 1'b0;
        chk("busy_cycles", n, eb);
        check_state();
    endtask

    task automatic set_dir(input logic [3:0] req);
        {up, down, left, right} = req;
        if (!mdead) mdir = pick_dir(mdir, req);
        @(negedge clock_25);
        {up, down, left, right} = 4'b0000;
        check_state();
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        if (!mdead) mpend = 1;
        @(negedge clock_25);
        grow = 1'b0;
    endtask

    task automatic pulse_restart(input bit with_noise);
        restart = 1'b1;
        move_tick = with_noise;
        grow = with_noise;
        @(negedge clock_25);
        restart = 1'b0; move_tick = 1'b0; grow = 1'b0;
        model_init();
        check_state();
        check_stream();
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] req;
        model_init();
        repeat (3) @(negedge clock_25);
        check_state();
        chk("reset_body_count", body_count, 0);
        chk("reset_stream", {snake_body_x, snake_body_y}, {7'd61, 7'd40});
        reset = 1'b1;
        @(negedge clock_25);
        check_stream();

        do_move(4'b0000, 0);
        repeat (10) @(negedge clock_25);
        do_move(4'b0000, 0);
        check_stream();

        pulse_grow();
        do_move(4'b0000, 0);
        check_stream();
        for (int i = 0; i < 13; i++) begin
            pulse_grow();
            do_move(4'b0000, 0);
        end
        chk("length_saturated_internal", mlen, 16);
        do_move(4'b0000, 0);
        check_stream();

        do_move(R_UP, 0);
        for (int i = 0; i < 45 && !mdead; i++) do_move(4'b0000, 0);
        chk("wall_dead", game_over, 1);
        pulse_grow();
        do_move(R_LEFT, 0);
        check_stream();
        pulse_restart(1);

        pulse_grow(); do_move(4'b0000, 0);
        pulse_grow(); do_move(4'b0000, 0);
        do_move(R_UP, 0);
        do_move(R_LEFT, 0);
        do_move(R_DOWN, 0);
        chk("self_collision_dead", game_over, 1);
        pulse_restart(0);

        set_dir(R_LEFT);
        do_move(4'b0000, 1);
        set_dir(R_UP | R_LEFT);
        set_dir(R_RIGHT);
        do_move(R_DOWN, 0);

        for (int op = 0; op < 90; op++) begin
            int r, k;
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 5);
            req = (k < 4) ? (4'b1000 >> k) : 4'b0000;
            if (r <= 4) begin
                do_move(req, 0);
            end else if (r <= 6) begin
                pulse_grow();
                do_move(req, 0);
            end else if (r <= 8) begin
                set_dir(req);
            end else begin
                check_stream();
            end
            if (mdead) begin
                do_move(R_UP, 0);
                check_stream();
                pulse_restart(r[0]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
